ddr_tcp_send: RTL

DDR_TCP_SEND -- requirements
Module: ddr_tcp_send

---
 rtl/ddr_tcp_send_pkg.sv | 33 +++
 rtl/blockram_fifo.sv | 57 +++++
 rtl/ddr_tcp_send.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ddr_tcp_send_pkg.sv
// Shared types and constants for the DDR-backed TCP send engine.
// Holds the FSM state encoding, TCP tx status codes and beat helpers.
package ddr_tcp_send_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_META,
        ST_STATUS,
        ST_READ_CMD,
        ST_DATA,
        ST_WAIT
    } state_t;

    // Error code carried in tx status data[63:62]
    localparam logic [1:0] TX_STATUS_OK       = 2'd0;
    localparam logic [1:0] TX_STATUS_NO_CONN  = 2'd1;
    localparam logic [1:0] TX_STATUS_NO_SPACE = 2'd2;
    localparam logic [1:0] TX_STATUS_CLOSED   = 2'd3;

    localparam int BEAT_BYTES = 64;

    function automatic logic [10:0] beats_of(input logic [15:0] len);
        return {1'b0, len[15:6]} + {10'd0, |len[5:0]};
    endfunction

    // Byte-enable for the final beat given length mod 64; zero means a full beat.
    function automatic logic [BEAT_BYTES-1:0] last_keep(input logic [5:0] rem);
        if (rem == 6'd0) return '1;
        return (64'd1 << rem) - 64'd1;
    endfunction

endpackage

// File: rtl/blockram_fifo.sv
// Synchronous single-clock FIFO on block RAM, one-cycle read latency.
// almostfull asserts with ALMOST_FULL or more entries stored.
module blockram_fifo #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = DEPTH - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             almostfull
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign do_wr      = wr_en & ~full;
    assign do_rd      = rd_en & ~empty;
    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(DEPTH));
    assign almostfull = (count >= (AW+1)'(ALMOST_FULL));

    // NOTE: storage and read register carry no reset so they map onto block RAM;
    // the empty flag guarantees stale contents are never presented as valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
        if (do_rd) rd_data <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_tcp_send.sv
// Streams per-session packets from DDR regions into the TCP tx path.
// Define TX_RETRY_EN to retry after TIME_OUT cycles on an error status.
module ddr_tcp_send
    import ddr_tcp_send_pkg::*;
#(
    parameter int unsigned SESSION_SIZE    = 32*1024*1024,
    parameter int unsigned MAX_SESSION_NUM = 16,
    parameter int unsigned TIME_OUT        = 250000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_axis_send_req_valid,
    output logic         s_axis_send_req_ready,
    input  logic [31:0]  s_axis_send_req_data,
    output logic         m_axis_tx_metadata_valid,
    input  logic         m_axis_tx_metadata_ready,
    output logic [31:0]  m_axis_tx_metadata_data,
    input  logic         s_axis_tx_status_valid,
    output logic         s_axis_tx_status_ready,
    input  logic [63:0]  s_axis_tx_status_data,
    output logic         m_axis_ddr_read_cmd_valid,
    input  logic         m_axis_ddr_read_cmd_ready,
    output logic [63:0]  m_axis_ddr_read_cmd_address,
    output logic [31:0]  m_axis_ddr_read_cmd_length,
    input  logic         s_axis_ddr_read_data_valid,
    output logic         s_axis_ddr_read_data_ready,
    input  logic [511:0] s_axis_ddr_read_data_data,
    input  logic [63:0]  s_axis_ddr_read_data_keep,
    input  logic         s_axis_ddr_read_data_last,
    output logic         m_axis_tx_data_valid,
    input  logic         m_axis_tx_data_ready,
    output logic [511:0] m_axis_tx_data_data,
    output logic [63:0]  m_axis_tx_data_keep,
    output logic         m_axis_tx_data_last,
    output logic [31:0]  sent_cnt,
    output logic [31:0]  err_cnt
);

    localparam int OFF_W  = $clog2(SESSION_SIZE);
    localparam int SIDX_W = $clog2(MAX_SESSION_NUM);
    localparam int TO_W   = $clog2(TIME_OUT + 1);

    state_t            state;
    logic [15:0]       req_len;
    logic [15:0]       req_sess;
    logic [10:0]       last_idx;
    logic [10:0]       beat_cnt;
    logic [63:0]       last_keep_r;
    logic [OFF_W-1:0]  off_tbl [MAX_SESSION_NUM];

    logic              fifo_wr;
    logic              fifo_rd;
    logic [31:0]       fifo_dout;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_afull;

    logic [SIDX_W-1:0] sidx;
    logic [OFF_W-1:0]  off_cur;
    logic [OFF_W-1:0]  off_use;
    logic [OFF_W-1:0]  off_next;
    logic [32:0]       off_sum;
    logic              data_phase;
    logic              final_beat;
    logic              beat_xfer;
    logic              unused_ok;

`ifdef TX_RETRY_EN
    logic [TO_W-1:0]   wait_cnt;
`endif

    blockram_fifo #(
        .WIDTH (32),
        .DEPTH (16)
    ) u_req_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (fifo_wr),
        .wr_data    (s_axis_send_req_data),
        .rd_en      (fifo_rd),
        .rd_data    (fifo_dout),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .almostfull (fifo_afull)
    );

    assign s_axis_send_req_ready = ~fifo_afull;
    assign fifo_wr = s_axis_send_req_valid & ~fifo_afull;
    assign fifo_rd = (state == ST_IDLE) & ~fifo_empty;

    // A request that would run past the end of its region restarts at offset 0.
    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sidx     = req_sess[SIDX_W-1:0];
        off_cur  = off_tbl[sidx];
        off_sum  = 33'(off_cur) + 33'(req_len);
        off_use  = off_cur;
        if (off_sum > 33'(SESSION_SIZE)) off_use = '0;
        off_next = off_use + OFF_W'(req_len);
    end

    // Zero-latency pass-through; last and keep are regenerated from the length.
    assign data_phase = (state == ST_DATA);
    assign final_beat = (beat_cnt == last_idx);
    assign beat_xfer  = data_phase & s_axis_ddr_read_data_valid & m_axis_tx_data_ready;

    assign m_axis_tx_data_valid       = data_phase & s_axis_ddr_read_data_valid;
    assign s_axis_ddr_read_data_ready = data_phase & m_axis_tx_data_ready;
    assign m_axis_tx_data_data        = s_axis_ddr_read_data_data;
    assign m_axis_tx_data_keep        = final_beat ? last_keep_r : '1;
    assign m_axis_tx_data_last        = data_phase & final_beat;
    assign m_axis_tx_metadata_data    = {req_len, req_sess};

    assign unused_ok = ^{s_axis_tx_status_data[61:0], s_axis_ddr_read_data_keep,
                         s_axis_ddr_read_data_last, fifo_full, TO_W[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state                       <= ST_IDLE;
            req_len                     <= '0;
            req_sess                    <= '0;
            last_idx                    <= '0;
            last_keep_r                 <= '0;
            beat_cnt                    <= '0;
            m_axis_tx_metadata_valid    <= 1'b0;
            s_axis_tx_status_ready      <= 1'b0;
            m_axis_ddr_read_cmd_valid   <= 1'b0;
            m_axis_ddr_read_cmd_address <= '0;
            m_axis_ddr_read_cmd_length  <= '0;
            sent_cnt                    <= '0;
            err_cnt                     <= '0;
            for (int i = 0; i < int'(MAX_SESSION_NUM); i++) off_tbl[i] <= '0;
`ifdef TX_RETRY_EN
            wait_cnt                    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) state <= ST_POP;
                end
                ST_POP: begin
                    req_len     <= fifo_dout[31:16];
                    req_sess    <= fifo_dout[15:0];
                    last_idx    <= beats_of(fifo_dout[31:16]) - 11'd1;
                    last_keep_r <= last_keep(fifo_dout[21:16]);
                    if (fifo_dout[31:16] == 16'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        m_axis_tx_metadata_valid <= 1'b1;
                        state                    <= ST_META;
                    end
                end
                ST_META: begin
                    if (m_axis_tx_metadata_ready) begin
                        m_axis_tx_metadata_valid <= 1'b0;
                        s_axis_tx_status_ready   <= 1'b1;
                        state                    <= ST_STATUS;
                    end
                end
                ST_STATUS: begin
                    if (s_axis_tx_status_valid) begin
                        s_axis_tx_status_ready <= 1'b0;
                        if (s_axis_tx_status_data[63:62] == TX_STATUS_OK) begin
                            m_axis_ddr_read_cmd_valid   <= 1'b1;
                            m_axis_ddr_read_cmd_address <= 64'({sidx, off_use});
                            m_axis_ddr_read_cmd_length  <= 32'(req_len);
                            state                       <= ST_READ_CMD;
                        end else begin
                            err_cnt <= err_cnt + 32'd1;
`ifdef TX_RETRY_EN
                            wait_cnt <= '0;
                            state    <= ST_WAIT;
`else
                            state    <= ST_IDLE;
`endif
                        end
                    end
                end
                ST_READ_CMD: begin
                    if (m_axis_ddr_read_cmd_ready) begin
                        m_axis_ddr_read_cmd_valid <= 1'b0;
                        off_tbl[sidx]             <= off_next;
                        beat_cnt                  <= '0;
                        state                     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_xfer) begin
                        if (final_beat) begin
                            sent_cnt <= sent_cnt + 32'd1;
                            state    <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 11'd1;
                        end
                    end
                end
`ifdef TX_RETRY_EN
                ST_WAIT: begin
                    if (wait_cnt == TO_W'(TIME_OUT)) begin
                        m_axis_tx_metadata_valid <= 1'b1;
                        state                    <= ST_META;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
